// File: rtl/noc_local_if.sv
// Local-port adapter between a processing element and its mesh router.
// Injection and ejection FIFOs, loopback for self-addressed offers, transfer counters and a sticky misroute flag.
module noc_local_if #(
    parameter int X_COORD       = 0,
    parameter int Y_COORD       = 0,
    parameter int PACKET_LENGTH = 32,
    parameter int COORD_W       = 4,
    parameter int TX_DEPTH      = 4,
    parameter int RX_DEPTH      = 4,
    localparam int PW           = PACKET_LENGTH - 4*COORD_W
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [COORD_W-1:0]       tx_dest_x,
    input  logic [COORD_W-1:0]       tx_dest_y,
    input  logic signed [PW-1:0]     tx_payload,
    output logic [PACKET_LENGTH-1:0] inj_packet,
    output logic                     inj_valid,
    input  logic                     inj_reading,
    input  logic [PACKET_LENGTH-1:0] ej_packet,
    input  logic                     ej_valid,
    output logic                     ej_is_read,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [COORD_W-1:0]       rx_src_x,
    output logic [COORD_W-1:0]       rx_src_y,
    output logic signed [PW-1:0]     rx_payload,
    output logic [15:0]              inj_count,
    output logic [15:0]              ej_count,
    output logic                     err_misroute
);

    localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int TX_CW = $clog2(TX_DEPTH + 1);
    localparam int RX_CW = $clog2(RX_DEPTH + 1);
    localparam int DX_HI = PACKET_LENGTH - 1;
    localparam int DY_HI = PACKET_LENGTH - 1 - COORD_W;
    localparam int SX_HI = PACKET_LENGTH - 1 - 2*COORD_W;
    localparam int SY_HI = PACKET_LENGTH - 1 - 3*COORD_W;

    localparam logic [COORD_W-1:0] OWN_X    = COORD_W'(X_COORD);
    localparam logic [COORD_W-1:0] OWN_Y    = COORD_W'(Y_COORD);
    localparam logic [TX_AW-1:0]   TX_LAST  = TX_AW'(TX_DEPTH - 1);
    localparam logic [RX_AW-1:0]   RX_LAST  = RX_AW'(RX_DEPTH - 1);
    localparam logic [TX_CW-1:0]   TX_FULLC = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0]   RX_FULLC = RX_CW'(RX_DEPTH);

    logic [PACKET_LENGTH-1:0] tx_mem_q [TX_DEPTH];
    logic [PACKET_LENGTH-1:0] tx_mem_d [TX_DEPTH];
    logic [PACKET_LENGTH-1:0] rx_mem_q [RX_DEPTH];
    logic [PACKET_LENGTH-1:0] rx_mem_d [RX_DEPTH];
    logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [15:0]      inj_count_q, inj_count_d, ej_count_q, ej_count_d;
    logic             err_q, err_d;

    logic                     tx_self, tx_full, rx_full;
    logic                     tx_push, tx_pop, lb_push, rx_push, rx_pop, ej_wrong;
    logic [PACKET_LENGTH-1:0] tx_pkt, rx_wdata, rx_head;

    // Handshakes: a transfer happens on a rising edge where valid and the
    // accepting side's ready/read are both high; ready never depends on valid.
    assign tx_self  = (tx_dest_x == OWN_X) && (tx_dest_y == OWN_Y);
    assign tx_pkt   = {tx_dest_x, tx_dest_y, OWN_X, OWN_Y, tx_payload};
    assign tx_full  = (tx_cnt_q == TX_FULLC);
    assign rx_full  = (rx_cnt_q == RX_FULLC);

    // Loopback yields to a pending ejection so the RX write port is never contended.
    assign tx_ready = !arst && (tx_self ? (!rx_full && !ej_valid) : !tx_full);
    assign tx_push  = tx_valid && tx_ready && !tx_self;
    assign lb_push  = tx_valid && tx_ready && tx_self;

    assign inj_valid  = (tx_cnt_q != '0);
    assign inj_packet = inj_valid ? tx_mem_q[tx_rd_q] : '0;
    assign tx_pop     = inj_valid && inj_reading;

    assign ej_is_read = !arst && ej_valid && !rx_full;
    assign rx_push    = ej_is_read || lb_push;
    assign rx_wdata   = ej_is_read ? ej_packet : tx_pkt;
    assign ej_wrong   = (ej_packet[DX_HI -: COORD_W] != OWN_X) ||
                        (ej_packet[DY_HI -: COORD_W] != OWN_Y);

    assign rx_valid   = (rx_cnt_q != '0);
    assign rx_head    = rx_valid ? rx_mem_q[rx_rd_q] : '0;
    assign rx_pop     = rx_valid && rx_ready;
    assign rx_src_x   = rx_head[SX_HI -: COORD_W];
    assign rx_src_y   = rx_head[SY_HI -: COORD_W];
    assign rx_payload = rx_head[PW-1:0];

    assign inj_count    = inj_count_q;
    assign ej_count     = ej_count_q;
    assign err_misroute = err_q;

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = tx_pkt;
            tx_wr_d = (tx_wr_q == TX_LAST) ? '0 : tx_wr_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rd_d = (tx_rd_q == TX_LAST) ? '0 : tx_rd_q + 1'b1;
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = rx_wdata;
            rx_wr_d = (rx_wr_q == RX_LAST) ? '0 : rx_wr_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rd_d = (rx_rd_q == RX_LAST) ? '0 : rx_rd_q + 1'b1;
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_comb begin
        inj_count_d = tx_pop     ? inj_count_q + 16'd1 : inj_count_q;
        ej_count_d  = ej_is_read ? ej_count_q + 16'd1  : ej_count_q;
        err_d       = err_q || (ej_is_read && ej_wrong);
    end

    // Storage is qualified by the occupancy counts, so it needs no reset.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            inj_count_q <= '0;
            ej_count_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            rx_cnt_q    <= rx_cnt_d;
            inj_count_q <= inj_count_d;
            ej_count_q  <= ej_count_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_noc_local_if.sv
// Bench for noc_local_if at mesh position (1,2): queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_noc_local_if;

    logic               clk = 1'b0;
    logic               arst;
    logic               tx_valid, tx_ready;
    logic [3:0]         tx_dest_x, tx_dest_y;
    logic signed [15:0] tx_payload;
    logic [31:0]        inj_packet;
    logic               inj_valid, inj_reading;
    logic [31:0]        ej_packet;
    logic               ej_valid, ej_is_read;
    logic               rx_valid, rx_ready;
    logic [3:0]         rx_src_x, rx_src_y;
    logic signed [15:0] rx_payload;
    logic [15:0]        inj_count, ej_count;
    logic               err_misroute;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [15:0] m_inj_cnt = '0;
    logic [15:0] m_ej_cnt  = '0;
    logic        m_err     = 1'b0;

    always #5 clk = ~clk;

    noc_local_if #(
        .X_COORD(1), .Y_COORD(2), .PACKET_LENGTH(32), .COORD_W(4),
        .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk), .arst(arst),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_payload(tx_payload),
        .inj_packet(inj_packet), .inj_valid(inj_valid), .inj_reading(inj_reading),
        .ej_packet(ej_packet), .ej_valid(ej_valid), .ej_is_read(ej_is_read),
        .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_src_x(rx_src_x), .rx_src_y(rx_src_y), .rx_payload(rx_payload),
        .inj_count(inj_count), .ej_count(ej_count), .err_misroute(err_misroute)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_self();
        return (tx_dest_x == 4'd1) && (tx_dest_y == 4'd2);
    endfunction

    function automatic logic m_tx_ready();
        if (m_self()) return (rx_q.size() < 4) && !ej_valid;
        return tx_q.size() < 4;
    endfunction

    function automatic logic m_ej_read();
        return ej_valid && (rx_q.size() < 4);
    endfunction

    // Reference model: one transaction step per rising edge, from inputs and queue occupancy.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            tx_q.delete();
            rx_q.delete();
            m_inj_cnt = '0;
            m_ej_cnt  = '0;
            m_err     = 1'b0;
        end else begin
            logic        acc, self, ej, inj, rxp;
            logic [31:0] offer;
            offer = {tx_dest_x, tx_dest_y, 4'd1, 4'd2, tx_payload};
            self  = m_self();
            acc   = tx_valid && m_tx_ready();
            ej    = m_ej_read();
            inj   = (tx_q.size() > 0) && inj_reading;
            rxp   = (rx_q.size() > 0) && rx_ready;
            if (inj) begin
                void'(tx_q.pop_front());
                m_inj_cnt = m_inj_cnt + 16'd1;
            end
            if (rxp) void'(rx_q.pop_front());
            if (ej) begin
                rx_q.push_back(ej_packet);
                m_ej_cnt = m_ej_cnt + 16'd1;
                if (ej_packet[31:24] != 8'h12) m_err = 1'b1;
            end
            if (acc && !self) tx_q.push_back(offer);
            if (acc && self)  rx_q.push_back(offer);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] th, rh;
            th = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
            rh = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
            if (arst) begin
                check("rst_inj_valid", inj_valid, 0);
                check("rst_inj_packet", inj_packet, 0);
                check("rst_rx_valid", rx_valid, 0);
                check("rst_rx_payload", {48'b0, rx_payload}, 0);
                check("rst_ej_is_read", ej_is_read, 0);
                check("rst_counts", {32'b0, inj_count, ej_count}, 0);
                check("rst_err", err_misroute, 0);
            end else begin
                check("m_tx_ready", tx_ready, m_tx_ready());
                check("m_ej_is_read", ej_is_read, m_ej_read());
                check("m_inj_valid", inj_valid, tx_q.size() > 0);
                check("m_inj_packet", inj_packet, th);
                check("m_rx_valid", rx_valid, rx_q.size() > 0);
                check("m_rx_src_x", rx_src_x, rh[23:20]);
                check("m_rx_src_y", rx_src_y, rh[19:16]);
                check("m_rx_payload", {48'b0, rx_payload}, rh[15:0]);
                check("m_inj_count", inj_count, m_inj_cnt);
                check("m_ej_count", ej_count, m_ej_cnt);
                check("m_err", err_misroute, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        arst        = 1'b1;
        tx_valid    = 1'b0;
        ej_valid    = 1'b0;
        inj_reading = 1'b0;
        rx_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;
    endtask

    task automatic offer(input logic [3:0] dx, input logic [3:0] dy, input logic [15:0] p);
        tx_valid   = 1'b1;
        tx_dest_x  = dx;
        tx_dest_y  = dy;
        tx_payload = p;
    endtask

    initial begin
        arst = 1'b1;
        tx_valid = 1'b0; tx_dest_x = '0; tx_dest_y = '0; tx_payload = '0;
        inj_reading = 1'b0; ej_packet = '0; ej_valid = 1'b0; rx_ready = 1'b0;
        cmp_en = 1'b1;
        #3;
        check("init_inj_valid", inj_valid, 0);
        check("init_rx_valid", rx_valid, 0);
        check("init_inj_count", inj_count, 0);
        do_reset();

        // single injection, router consuming
        inj_reading = 1'b1;
        offer(4'd3, 4'd0, 16'h8001);
        #1 check("t1_tx_ready", tx_ready, 1);
        tick();
        tx_valid = 1'b0;
        check("t1_inj_valid", inj_valid, 1);
        check("t1_inj_packet", inj_packet, 32'h3012_8001);
        tick();
        check("t1_popped", inj_valid, 0);
        check("t1_inj_count", inj_count, 1);

        // TX FIFO fill with router stalled, then in-order drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            offer(4'd0, 4'd1, 16'h0100 + 16'(i));
            #1 check("fill_tx_ready", tx_ready, i < 4);
            tick();
        end
        tx_valid = 1'b0;
        inj_reading = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_inj_packet", inj_packet, 32'h0112_0100 + 32'(i));
            tick();
        end
        check("drain_empty", inj_valid, 0);
        check("drain_inj_count", inj_count, 4);

        // loopback, and loopback blocked by a pending ejection
        do_reset();
        offer(4'd1, 4'd2, 16'h00AA);
        #1 check("lb_tx_ready", tx_ready, 1);
        tick();
        tx_valid = 1'b0;
        check("lb_rx_valid", rx_valid, 1);
        check("lb_rx_src", {56'b0, rx_src_x, rx_src_y}, 8'h12);
        check("lb_rx_payload", {48'b0, rx_payload}, 16'h00AA);
        check("lb_no_inj", inj_valid, 0);
        offer(4'd1, 4'd2, 16'h00BB);
        ej_packet = 32'h1234_0055;
        ej_valid  = 1'b1;
        #1 check("lb_blocked", tx_ready, 0);
        check("lb_ej_wins", ej_is_read, 1);
        tick();
        tx_valid = 1'b0;
        ej_valid = 1'b0;
        rx_ready = 1'b1;
        check("lb_head0", {48'b0, rx_payload}, 16'h00AA);
        tick();
        check("lb_head1_src", {56'b0, rx_src_x, rx_src_y}, 8'h34);
        check("lb_head1_payload", {48'b0, rx_payload}, 16'h0055);
        tick();
        check("lb_rx_empty", rx_valid, 0);
        rx_ready = 1'b0;

        // RX FIFO fill from the router, then in-order drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ej_packet = 32'h1256_0010 + 32'(i);
            ej_valid  = 1'b1;
            #1 check("ej_fill_read", ej_is_read, i < 4);
            tick();
        end
        ej_valid = 1'b0;
        check("ej_count4", ej_count, 4);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ej_drain_payload", {48'b0, rx_payload}, 16'h0010 + 16'(i));
            check("ej_drain_src", {56'b0, rx_src_x, rx_src_y}, 8'h56);
            tick();
        end
        check("ej_drain_empty", rx_valid, 0);
        rx_ready = 1'b0;

        // mixed traffic against the model
        do_reset();
        repeat (400) begin
            int sel;
            sel = $urandom_range(0, 2);
            tx_valid   = 1'($urandom_range(0, 1));
            tx_dest_x  = (sel == 0) ? 4'd1 : (sel == 1) ? 4'd3 : 4'd0;
            tx_dest_y  = (sel == 0) ? 4'd2 : (sel == 1) ? 4'd0 : 4'd1;
            tx_payload = 16'($urandom_range(0, 65535));
            ej_valid   = ($urandom_range(0, 2) == 0);
            ej_packet  = {8'h12, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535))};
            inj_reading = 1'($urandom_range(0, 1));
            rx_ready    = 1'($urandom_range(0, 1));
            tick();
        end
        tx_valid = 1'b0; ej_valid = 1'b0; inj_reading = 1'b1; rx_ready = 1'b1;
        repeat (8) tick();
        check("mix_tx_drained", inj_valid, 0);
        check("mix_rx_drained", rx_valid, 0);
        check("mix_no_err", err_misroute, 0);

        // misroute flag, then reset with both FIFOs full
        do_reset();
        ej_packet = 32'h2212_0077;
        ej_valid  = 1'b1;
        tick();
        ej_valid = 1'b0;
        check("mr_err", err_misroute, 1);
        check("mr_delivered", rx_valid, 1);
        check("mr_payload", {48'b0, rx_payload}, 16'h0077);
        repeat (3) tick();
        check("mr_sticky", err_misroute, 1);
        for (int i = 0; i < 4; i++) begin
            offer(4'd3, 4'd0, 16'h0200 + 16'(i));
            ej_packet = 32'h1256_0300 + 32'(i);
            ej_valid  = (i < 3);
            tick();
        end
        tx_valid = 1'b0;
        ej_valid = 1'b1;
        #1 check("full_ej_blocked", ej_is_read, 0);
        check("full_inj_valid", inj_valid, 1);
        #1 arst = 1'b1;
        #2;
        check("arst_inj_valid", inj_valid, 0);
        check("arst_inj_packet", inj_packet, 0);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_rx_out", {40'b0, rx_src_x, rx_src_y, rx_payload}, 0);
        check("arst_ej_is_read", ej_is_read, 0);
        check("arst_counts", {32'b0, inj_count, ej_count}, 0);
        check("arst_err", err_misroute, 0);
        ej_valid = 1'b0;
        offer(4'd0, 4'd1, 16'h0ABC);
        @(posedge clk);
        #2 arst = 1'b0;
        #1 check("post_rst_no_inj", inj_valid, 0);
        check("post_rst_no_rx", rx_valid, 0);
        tick();
        tx_valid = 1'b0;
        check("first_xfer_valid", inj_valid, 1);
        check("first_xfer_packet", inj_packet, 32'h0112_0ABC);
        tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noc_local_if.md
NOC_LOCAL_IF -- requirements
Module: noc_local_if

Interface
REQ-001 SHALL have parameters: X_COORD, 0, own mesh column; Y_COORD, 0, own mesh row; PACKET_LENGTH, 32, packet width; COORD_W, 4, coordinate field width; TX_DEPTH, 4, injection FIFO entries; RX_DEPTH, 4, ejection FIFO entries.
REQ-002 SHALL define packet layout MSB-first: dest_x, dest_y, src_x, src_y (COORD_W each), then signed payload of PW = PACKET_LENGTH-4*COORD_W bits.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  PE offers a payload.
- tx_ready  out  1  PE offer accepted this cycle.
- tx_dest_x, tx_dest_y  in  COORD_W  destination.
- tx_payload  in  PW  signed payload.
- inj_packet  out  PACKET_LENGTH  packet to router local input.
- inj_valid  out  1  inj_packet valid.
- inj_reading  in  1  router consumes inj_packet this cycle.
- ej_packet  in  PACKET_LENGTH  packet from router local output.
- ej_valid  in  1  ej_packet valid.
- ej_is_read  out  1  this block consumes ej_packet this cycle.
- rx_valid  out  1  received packet available to PE.
- rx_ready  in  1  PE takes rx data this cycle.
- rx_src_x, rx_src_y  out  COORD_W  sender coordinates.
- rx_payload  out  PW  signed payload.
- inj_count, ej_count  out  16  transfer counters.
- err_misroute  out  1  sticky misroute flag.

Function
REQ-004 SHALL build packets as {tx_dest_x, tx_dest_y, X_COORD, Y_COORD, tx_payload}.
REQ-005 SHALL classify an offer as self-addressed when tx_dest_x==X_COORD and tx_dest_y==Y_COORD.
REQ-006 Non-self offer: tx_ready = TX FIFO not full; on tx_valid&&tx_ready push packet into TX FIFO.
REQ-007 Self offer: tx_ready = RX FIFO not full and ej_valid==0; on accept push packet directly into RX FIFO (loopback; router local port never carries self-addressed traffic).
REQ-008 tx_ready SHALL be combinational from FIFO state, tx_dest and ej_valid; it is independent of tx_valid.
REQ-009 inj_valid = TX FIFO not empty; inj_packet = TX FIFO head, held stable until popped.
REQ-010 SHALL pop TX FIFO when inj_valid&&inj_reading; a packet pushed at edge N is presented no earlier than cycle N+1.
REQ-011 TX FIFO SHALL support simultaneous push and pop in one cycle, including when full (the pop does not free the push slot that cycle; full blocks push).
REQ-012 ej_is_read = ej_valid && RX FIFO not full (combinational); on assertion push ej_packet into RX FIFO.
REQ-013 Ejection SHALL take priority over loopback for the RX FIFO write port; at most one RX push per cycle.
REQ-014 rx_valid = RX FIFO not empty; rx_src_x/rx_src_y/rx_payload decode the RX head; pop on rx_valid&&rx_ready.
REQ-015 RX FIFO SHALL support simultaneous push and pop when neither full nor empty-blocked; full blocks push regardless of pop.
REQ-016 Both FIFOs SHALL preserve order; pointers wrap modulo depth; depth need not be a power of two.
REQ-017 inj_count SHALL increment on each TX pop, ej_count on each ej_is_read; both wrap 16'hFFFF->0.
REQ-018 err_misroute SHALL set when an ejected packet's dest_x/dest_y differ from X_COORD/Y_COORD; the packet is still delivered; clears only on reset.
REQ-019 With rx_valid held and rx_ready low, RX head data SHALL remain unchanged.

Reset
REQ-020 arst high SHALL immediately empty both FIFOs and drive inj_valid=0, rx_valid=0, ej_is_read=0, inj_packet=0, rx outputs=0, counters=0, err_misroute=0.
REQ-021 Reset mid-transfer SHALL discard all buffered packets; no partial packet is emitted after deassertion.
REQ-022 First transfer SHALL be possible on the first rising edge after arst deasserts.

Verification (X_COORD=1, Y_COORD=2, COORD_W=4, PACKET_LENGTH=32, depths 4)
REQ-023 Offer dest (3,0) payload 16'sh8001, inj_reading held 1 -> inj_packet=32'h3012_8001 at next cycle, popped same cycle, inj_count=1.
REQ-024 inj_reading held 0, five non-self offers -> four accepted, tx_ready=0 on fifth; release inj_reading -> four packets out in order, one per cycle.
REQ-025 Self offer dest (1,2) payload 16'h00AA with ej_valid=0 -> rx_valid next cycle, rx_src=(1,2), rx_payload=16'h00AA, inj_valid stays 0; repeat with ej_valid=1 -> tx_ready=0.
REQ-026 rx_ready=0, five ejections to (1,2) -> ej_is_read high for four, low on fifth, ej_count=4; rx_ready=1 -> FIFO order drains.
REQ-027 Ejection of packet dest (2,2) -> err_misroute=1 persisting, packet delivered; assert arst with full FIFOs -> all outputs 0 immediately.
